cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 3: number of functional-unit result sources (adder, multiplier, load).
REQ-002 SHALL have parameter DW, default 16: result data width.
REQ-003 SHALL have parameter TW, default 3: reservation-station tag width; tag 0 means "no producer".
REQ-004 SHALL have port clk1, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port fu_valid, input, NSRC: per-source result valid.
REQ-007 SHALL have port fu_ready, output, NSRC: per-source accept; transfer occurs when fu_valid[i] and fu_ready[i] are both high at an edge.
REQ-008 SHALL have port fu_tag, input, NSRC*TW: per-source tags, source i at bits [i*TW +: TW].
REQ-009 SHALL have port fu_data, input, NSRC*DW: per-source results, source i at bits [i*DW +: DW].
REQ-010 SHALL have port cdb_valid, output, 1: broadcast valid, one cycle per result.
REQ-011 SHALL have port cdb_tag, output, TW: broadcast tag.
REQ-012 SHALL have port cdb_data, output, DW: broadcast value.
REQ-013 SHALL have port cdb_src, output, $clog2(NSRC): index of the granted source.
REQ-014 SHALL have port cdb_err, output, 1: sticky flag, set on a tag-0 transfer.
REQ-015 SHALL have port cdb_count, output, 16: broadcast counter (see Configuration).

Function
REQ-016 SHALL hold a 2-entry FIFO per source with entries {tag, data} and count 0..2.
REQ-017 SHALL drive fu_ready[i] = (count[i] < 2), from registered count only, with no combinational path from the same-cycle pop.
REQ-018 Push and pop on the same FIFO in the same cycle SHALL leave the count unchanged and preserve order.
REQ-019 A transfer with tag 0 SHALL be consumed (ready honoured), SHALL NOT be stored, and SHALL set cdb_err.
REQ-020 Each cycle, SHALL grant at most one non-empty FIFO, searching round-robin from rr_ptr upward with wrap NSRC-1 -> 0.
REQ-021 After a grant to source g, rr_ptr SHALL become (g+1) mod NSRC; with no grant, rr_ptr SHALL hold.
REQ-022 The granted head SHALL be popped and registered onto cdb_tag/cdb_data/cdb_src with cdb_valid=1 at that same edge.
REQ-023 With no grant, cdb_valid SHALL be 0; cdb_tag, cdb_data and cdb_src SHALL hold their previous values.
REQ-024 Latency SHALL be: a result accepted into an empty FIFO at edge N with no competitor is broadcast at edge N+1, i.e. visible after N+1.
REQ-025 Sustained throughput SHALL be one broadcast per cycle; no source SHALL wait more than NSRC-1 grants once its FIFO is non-empty.

Reset
REQ-026 rst high at an edge SHALL clear all FIFO counts and pointers, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, cdb_err=0 and cdb_count=0.
REQ-027 rst SHALL override any simultaneous push or pop; in-flight FIFO contents SHALL be discarded.
REQ-028 fu_ready SHALL be all ones in the cycle after reset.

Configuration
REQ-029 Macro CDB_STATS_EN defined: cdb_count SHALL increment by 1 on every edge where cdb_valid is set, wrapping 0xFFFF -> 0.
REQ-030 Macro CDB_STATS_EN undefined: cdb_count SHALL be constant 0 and no counter logic SHALL be built; all other behaviour is unchanged.

Verification
REQ-031 Single result: source 1 pushes tag 3 / data 0x0042 at edge N -> at edge N+1 cdb_valid=1, tag 3, data 0x0042, src 1; at edge N+2 cdb_valid=0.
REQ-032 Contention: all three sources push tags 1, 2, 3 in the same cycle from reset -> broadcasts on three consecutive cycles in src order 0, 1, 2.
REQ-033 Full FIFO: source 2 valid every cycle while source 0 is valid continuously and source 1 is idle -> source 2 fu_ready drops after its 2 entries are stored, alternates grants with source 0, and no result is lost or reordered.
REQ-034 Tag 0: source 0 pushes tag 0 / data 0x1234 -> no broadcast, cdb_err=1 and stays 1 until rst.
REQ-035 Reset mid-operation: FIFOs hold 4 entries total and rst is asserted for 1 cycle -> no broadcast follows, fu_ready=3'b111, and the next grant goes to src 0 first.
REQ-036 With CDB_STATS_EN defined: 5 broadcasts -> cdb_count=5; without the macro -> cdb_count=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: a 2-entry FIFO per result source and a round-robin grant onto a registered broadcast bus.
// Define CDB_STATS_EN to build the 16-bit broadcast counter on cdb_count; without it cdb_count is tied to zero.
module cdb_arbiter #(
    parameter int NSRC = 3,
    parameter int DW   = 16,
    parameter int TW   = 3
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic [NSRC-1:0]           fu_valid,
    output logic [NSRC-1:0]           fu_ready,
    input  logic [NSRC*TW-1:0]        fu_tag,
    input  logic [NSRC*DW-1:0]        fu_data,
    output logic                      cdb_valid,
    output logic [TW-1:0]             cdb_tag,
    output logic [DW-1:0]             cdb_data,
    output logic [$clog2(NSRC)-1:0]   cdb_src,
    output logic                      cdb_err,
    output logic [15:0]               cdb_count
);
    localparam int SW = $clog2(NSRC);

    logic [TW-1:0]   tag_mem  [NSRC][2];
    logic [DW-1:0]   data_mem [NSRC][2];
    logic [1:0]      cnt_q [NSRC];
    logic [1:0]      cnt_d [NSRC];
    logic [NSRC-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [SW-1:0]   rr_q, rr_d, gnt_idx;
    logic            gnt_any;
    logic [NSRC-1:0] accept, push, pop;
    logic            valid_q, err_q, err_d;
    logic [TW-1:0]   tag_q;
    logic [DW-1:0]   data_q;
    logic [SW-1:0]   src_q;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            fu_ready[i] = (cnt_q[i] < 2'd2);
            accept[i]   = fu_valid[i] & fu_ready[i];
            push[i]     = accept[i] & (fu_tag[i*TW +: TW] != '0);
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!gnt_any && cnt_q[idx] != 2'd0) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            pop[i]   = gnt_any && (gnt_idx == SW'(i));
            cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
        end
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        err_d = err_q | (|(accept & ~push));
        if (!gnt_any)                         rr_d = rr_q;
        else if (gnt_idx == SW'(NSRC - 1))    rr_d = '0;
        else                                  rr_d = gnt_idx + 1'b1;
    end

    // Storage needs no reset: the pointers and counts define which entries are live.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wp_q[i]]  <= fu_tag[i*TW +: TW];
                data_mem[i][wp_q[i]] <= fu_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) cnt_q[i] <= 2'd0;
            wp_q    <= '0;
            rp_q    <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) cnt_q[i] <= cnt_d[i];
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            valid_q <= gnt_any;
            if (gnt_any) begin
                tag_q  <= tag_mem[gnt_idx][rp_q[gnt_idx]];
                data_q <= data_mem[gnt_idx][rp_q[gnt_idx]];
                src_q  <= gnt_idx;
            end
        end
    end

`ifdef CDB_STATS_EN
    logic [15:0] count_q;
    always_ff @(posedge clk1) begin
        if (rst)          count_q <= '0;
        else if (gnt_any) count_q <= count_q + 16'd1;
    end
    assign cdb_count = count_q;
`else
    assign cdb_count = '0;
`endif

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign cdb_src   = src_q;
    assign cdb_err   = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle, directed scenarios with literal pins, then random traffic.
module tb_cdb_arbiter;
    localparam int NSRC = 3;
    localparam int DW   = 16;
    localparam int TW   = 3;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic [NSRC-1:0]   fu_valid = '0;
    logic [NSRC-1:0]   fu_ready;
    logic [NSRC*TW-1:0] fu_tag = '0;
    logic [NSRC*DW-1:0] fu_data = '0;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [1:0]        cdb_src;
    logic              cdb_err;
    logic [15:0]       cdb_count;

    always #5 clk1 = ~clk1;

    cdb_arbiter #(.NSRC(NSRC), .DW(DW), .TW(TW)) dut (
        .clk1(clk1), .rst(rst),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_data(fu_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_src(cdb_src), .cdb_err(cdb_err), .cdb_count(cdb_count)
    );

    int errors = 0;
    int checks = 0;
    bit inited = 0;

    // Reference model: one queue of {tag,data} per source plus the visible bus state.
    logic [TW+DW-1:0] mq [NSRC][$];
    int               rr = 0;
    logic             e_valid = 0, e_err = 0;
    logic [TW-1:0]    e_tag = 0;
    logic [DW-1:0]    e_data = 0;
    logic [1:0]       e_src = 0;
    logic [15:0]      e_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NSRC-1:0] model_ready();
        logic [NSRC-1:0] r;
        for (int i = 0; i < NSRC; i++) r[i] = (mq[i].size() < 2);
        return r;
    endfunction

    task automatic model_step(input logic [NSRC-1:0] v, input logic [NSRC*TW-1:0] t,
                              input logic [NSRC*DW-1:0] d, input logic r);
        int g;
        logic [NSRC-1:0] rdy;
        logic [TW+DW-1:0] ent;
        logic [TW-1:0] tg;
        if (r) begin
            for (int i = 0; i < NSRC; i++) mq[i].delete();
            rr = 0; e_valid = 0; e_tag = 0; e_data = 0; e_src = 0; e_err = 0; e_cnt = 0;
            return;
        end
        rdy = model_ready();
        g = -1;
        for (int k = 0; k < NSRC; k++) begin
            int idx = (rr + k) % NSRC;
            if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        if (g >= 0) begin
            ent = mq[g].pop_front();
            e_valid = 1;
            e_tag = ent[TW+DW-1:DW];
            e_data = ent[DW-1:0];
            e_src = 2'(g);
            rr = (g + 1) % NSRC;
`ifdef CDB_STATS_EN
            e_cnt = e_cnt + 16'd1;
`endif
        end else begin
            e_valid = 0;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (v[i] && rdy[i]) begin
                tg = t[i*TW +: TW];
                if (tg == 0) e_err = 1;
                else mq[i].push_back({tg, d[i*DW +: DW]});
            end
        end
    endtask

    task automatic cycle(input logic [NSRC-1:0] v, input logic [NSRC*TW-1:0] t,
                         input logic [NSRC*DW-1:0] d, input logic r);
        fu_valid = v; fu_tag = t; fu_data = d; rst = r;
        #1;
        if (inited) chk("fu_ready", 32'(fu_ready), 32'(model_ready()));
        model_step(v, t, d, r);
        if (r) inited = 1;
        @(posedge clk1);
        #1;
        chk("cdb_valid", 32'(cdb_valid), 32'(e_valid));
        chk("cdb_tag",   32'(cdb_tag),   32'(e_tag));
        chk("cdb_data",  32'(cdb_data),  32'(e_data));
        chk("cdb_src",   32'(cdb_src),   32'(e_src));
        chk("cdb_err",   32'(cdb_err),   32'(e_err));
        chk("cdb_count", 32'(cdb_count), 32'(e_cnt));
    endtask

    task automatic idle();
        cycle('0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        cycle('0, '0, '0, 1'b1);
    endtask

    function automatic logic [NSRC*TW-1:0] tg3(input int t0, input int t1, input int t2);
        return {3'(t2), 3'(t1), 3'(t0)};
    endfunction

    function automatic logic [NSRC*DW-1:0] dd3(input int d0, input int d1, input int d2);
        return {16'(d2), 16'(d1), 16'(d0)};
    endfunction

    initial begin
        logic [NSRC-1:0] v;
        logic [NSRC*TW-1:0] t;
        logic [NSRC*DW-1:0] d;
        int p;

        do_reset();
        do_reset();
        chk("reset_valid", 32'(cdb_valid), 32'd0);
        chk("reset_ready", 32'(fu_ready), 32'b111);
        chk("reset_err", 32'(cdb_err), 32'd0);
        chk("reset_count", 32'(cdb_count), 32'd0);

        // Contention from reset: broadcasts in source order 0,1,2.
        cycle(3'b111, tg3(1, 2, 3), dd3('h11, 'h22, 'h33), 1'b0);
        chk("cont_none_yet", 32'(cdb_valid), 32'd0);
        idle(); chk("cont_src0", 32'(cdb_src), 32'd0); chk("cont_tag1", 32'(cdb_tag), 32'd1);
        idle(); chk("cont_src1", 32'(cdb_src), 32'd1); chk("cont_tag2", 32'(cdb_tag), 32'd2);
        idle(); chk("cont_src2", 32'(cdb_src), 32'd2); chk("cont_tag3", 32'(cdb_tag), 32'd3);
        idle(); chk("cont_done", 32'(cdb_valid), 32'd0);

        // Single result latency.
        cycle(3'b010, tg3(0, 3, 0), dd3(0, 'h0042, 0), 1'b0);
        chk("single_edgeN", 32'(cdb_valid), 32'd0);
        idle();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_tag", 32'(cdb_tag), 32'd3);
        chk("single_data", 32'(cdb_data), 32'h0042);
        chk("single_src", 32'(cdb_src), 32'd1);
        idle();
        chk("single_after", 32'(cdb_valid), 32'd0);
        chk("single_hold_data", 32'(cdb_data), 32'h0042);

        cycle(3'b001, tg3(5, 0, 0), dd3('h5555, 0, 0), 1'b0);
        idle(); idle();
`ifdef CDB_STATS_EN
        chk("count_five", 32'(cdb_count), 32'd5);
`else
        chk("count_five", 32'(cdb_count), 32'd0);
`endif

        // Tag 0 is swallowed and sets the sticky error.
        cycle(3'b001, tg3(0, 0, 0), dd3('h1234, 0, 0), 1'b0);
        chk("tag0_err", 32'(cdb_err), 32'd1);
        idle();
        chk("tag0_nobcast", 32'(cdb_valid), 32'd0);
        idle(); idle();
        chk("tag0_sticky", 32'(cdb_err), 32'd1);

        // Full FIFO: sources 0 and 2 always valid, source 1 idle.
        do_reset();
        chk("err_cleared", 32'(cdb_err), 32'd0);
        for (int n = 0; n < 12; n++) begin
            cycle(3'b101, tg3(n % 7 + 1, 0, (n + 3) % 7 + 1), dd3(n, 0, 'h100 + n), 1'b0);
            if (n == 1) begin
                chk("full_ready_e2", 32'(fu_ready), 32'b011);
                chk("full_src_e2", 32'(cdb_src), 32'd0);
            end
            if (n == 2) begin
                chk("full_ready_e3", 32'(fu_ready), 32'b110);
                chk("full_src_e3", 32'(cdb_src), 32'd2);
            end
        end
        for (int n = 0; n < 5; n++) idle();

        // Reset with four entries in flight.
        do_reset();
        cycle(3'b111, tg3(1, 2, 3), dd3(1, 2, 3), 1'b0);
        cycle(3'b111, tg3(4, 5, 6), dd3(4, 5, 6), 1'b0);
        idle();
        cycle(3'b111, tg3(7, 7, 7), dd3(7, 7, 7), 1'b1);
        chk("rst_mid_valid", 32'(cdb_valid), 32'd0);
        chk("rst_mid_ready", 32'(fu_ready), 32'b111);
        idle();
        chk("rst_mid_nobcast", 32'(cdb_valid), 32'd0);
        cycle(3'b111, tg3(1, 2, 3), dd3(9, 9, 9), 1'b0);
        idle();
        chk("rst_mid_src0", 32'(cdb_src), 32'd0);
        chk("rst_mid_v", 32'(cdb_valid), 32'd1);

        // Random traffic with occasional resets and tag-0 transfers.
        for (int n = 0; n < 3000; n++) begin
            p = ((n / 200) % 3 == 0) ? 95 : 50;
            for (int i = 0; i < NSRC; i++) begin
                v[i] = ($urandom_range(0, 99) < p);
                t[i*TW +: TW] = ($urandom_range(0, 49) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                d[i*DW +: DW] = 16'($urandom);
            end
            cycle(v, t, d, ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
